// File: rtl/seq_divider_if.sv
// seq_divider_if: divider request/result bundle; master drives operands and controls, slave returns result and ready
interface seq_divider_if #(parameter int WIDTH = 32);
  logic signed_div;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic start;
  logic annul;
  logic [2*WIDTH-1:0] result;
  logic ready;
  modport master(output signed_div, a, b, start, annul, input result, ready);
  modport slave(input signed_div, a, b, start, annul, output result, ready);
endinterface

// File: rtl/seq_divider.sv
// seq_divider: restoring signed/unsigned divider, WIDTH steps; ports clk, rst (sync high), io (slave: operands/start/annul in, {rem,quo} result/ready out)
module seq_divider #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst,
  seq_divider_if.slave io
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, ZERO, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH:0] pr_q, pr_d, pr_step;
  logic [WIDTH-1:0] d_q, d_d, mag_a, mag_b, quo, rem;
  logic [WIDTH+1:0] trial;
  logic [2*WIDTH-1:0] res_q, res_d, res_fix;
  logic sgn_q, sgn_d, na_q, na_d, nb_q, nb_d;
  always_comb begin
    mag_a = (io.signed_div && io.a[WIDTH-1]) ? -io.a : io.a;
    mag_b = (io.signed_div && io.b[WIDTH-1]) ? -io.b : io.b;
    // a borrow out of the trial subtraction means the shifted remainder is below the divisor
    trial = {1'b0, pr_q[2*WIDTH-1:WIDTH-1]} - {2'b0, d_q};
    pr_step = trial[WIDTH+1] ? {pr_q[2*WIDTH-1:0], 1'b0} : {trial[WIDTH:0], pr_q[WIDTH-2:0], 1'b1};
    quo = pr_step[WIDTH-1:0];
    rem = pr_step[2*WIDTH-1:WIDTH];
    res_fix = {(sgn_q && na_q) ? -rem : rem, (sgn_q && (na_q ^ nb_q)) ? -quo : quo};
    state_d = state_q;
    cnt_d = cnt_q;
    pr_d = pr_q;
    d_d = d_q;
    res_d = res_q;
    sgn_d = sgn_q;
    na_d = na_q;
    nb_d = nb_q;
    case (state_q)
      IDLE: if (io.start && !io.annul) begin
        state_d = (io.b == '0) ? ZERO : BUSY;
        cnt_d = '0;
        pr_d = {{(WIDTH+1){1'b0}}, mag_a};
        d_d = mag_b;
        sgn_d = io.signed_div;
        na_d = io.a[WIDTH-1];
        nb_d = io.b[WIDTH-1];
      end
      ZERO: begin
        state_d = io.annul ? IDLE : DONE;
        res_d = io.annul ? res_q : '0;
      end
      BUSY: begin
        pr_d = pr_step;
        cnt_d = cnt_q + CW'(1);
        state_d = io.annul ? IDLE : (cnt_q == CW'(WIDTH - 1)) ? DONE : BUSY;
        res_d = (!io.annul && cnt_q == CW'(WIDTH - 1)) ? res_fix : res_q;
      end
      default: state_d = (io.annul || !io.start) ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pr_q <= '0;
      d_q <= '0;
      res_q <= '0;
      sgn_q <= 1'b0;
      na_q <= 1'b0;
      nb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pr_q <= pr_d;
      d_q <= d_d;
      res_q <= res_d;
      sgn_q <= sgn_d;
      na_q <= na_d;
      nb_q <= nb_d;
    end
  end
  assign io.result = res_q;
  assign io.ready = (state_q == DONE);
endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: WIDTH, default 32, operand width; result width is 2*WIDTH.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 signed_div  input  1  1 = two's-complement divide, 0 = unsigned.
REQ-005 a  input  WIDTH  dividend.
REQ-006 b  input  WIDTH  divisor.
REQ-007 start  input  1  request; the initiator holds it high until ready is seen, then drops it.
REQ-008 annul  input  1  abort the current operation.
REQ-009 result  output  2*WIDTH  {remainder, quotient}: result[2W-1:W] = remainder (HI), result[W-1:0] = quotient (LO).
REQ-010 ready  output  1  result valid; registered.

Function
REQ-011 The block SHALL implement the states IDLE, ZERO, BUSY and DONE, with IDLE as the reset state.
REQ-012 IDLE, start=1 and annul=0 at an edge (the capture edge, E0): the block SHALL latch signed_div, the sign of a and the sign of b, |a| and |b| (magnitudes only when signed_div=1; raw values otherwise), and clear the step counter.
REQ-013 IDLE transitions on the capture edge: b==0 SHALL go to ZERO; any other b SHALL go to BUSY.
REQ-014 IDLE with start=0, or with start=1 and annul=1: the block SHALL remain in IDLE with no capture.
REQ-015 BUSY: one restoring shift-subtract step SHALL execute per edge, MSB first, on a 2W+1-bit partial-remainder/quotient register; the counter SHALL increment each step.
REQ-016 Exactly WIDTH steps SHALL execute (edges E1..EW); the edge that performs step WIDTH SHALL load result and enter DONE.
REQ-017 Consequence of REQ-015/REQ-016: ready SHALL first be high in the cycle after edge EW, which is WIDTH cycles after E0.
REQ-018 Sign fix-up for signed_div=1 SHALL be applied when result is loaded: quotient is negated iff sign(a) != sign(b); remainder is negated iff a was negative (the remainder takes the dividend's sign).
REQ-019 Signed a = 0x80000000 with b = 0xFFFFFFFF SHALL wrap to quotient 0x80000000, remainder 0; no overflow flag is produced.
REQ-020 ZERO: the next edge SHALL load result = 0 and enter DONE, so ready is high 1 cycle after E0.
REQ-021 DONE: ready SHALL be 1 and result SHALL be held stable.
REQ-022 DONE with start=0 at an edge: the block SHALL go to IDLE and ready SHALL be 0 in the following cycle.
REQ-023 DONE with start still 1: the block SHALL remain in DONE and SHALL NOT restart.
REQ-024 Changes on start, a, b or signed_div during BUSY or ZERO SHALL be ignored; the operands are taken only from the capture edge.
REQ-025 annul=1 at an edge in BUSY, ZERO or DONE SHALL force IDLE with ready=0; result SHALL keep its previous value.
REQ-026 A new request SHALL be accepted at the first edge after returning to IDLE on which start=1 and annul=0.
REQ-027 result SHALL hold its last loaded value in IDLE until the next load.
REQ-028 ready SHALL be 1 only in DONE.
REQ-029 The block SHALL contain no combinational path from any input to ready or result.

Reset
REQ-030 rst=1 at an edge SHALL, in any state including mid-BUSY, set state=IDLE, ready=0, result=0, counter=0 and all latched operand/sign registers to 0.
REQ-031 rst SHALL take priority over start and annul.
REQ-032 The first request SHALL be accepted at the first edge after rst deasserts.

Verification
REQ-033 Unsigned: a=100, b=7 -> ready rises 32 cycles after E0, result = {32'd2, 32'd14}; start dropped -> ready=0 next cycle.
REQ-034 Signed: a=0xFFFFFFF9 (-7), b=2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); the same operands unsigned -> quotient 0x7FFFFFFC, remainder 1.
REQ-035 Divide by zero: a=5, b=0 (both modes) -> ready 1 cycle after E0, result = 0.
REQ-036 Signed a=0x80000000, b=0xFFFFFFFF -> quotient 0x80000000, remainder 0, latency 32.
REQ-037 annul=1 for one cycle 10 cycles after E0 -> ready never asserts and result is unchanged; next request a=0xFFFFFFFF, b=0x10 unsigned -> quotient 0x0FFFFFFF, remainder 0xF.
REQ-038 rst pulsed 5 cycles after E0 -> ready=0 and result=0 next cycle; start held high after reset -> fresh capture and correct result 32 cycles later; start held high in DONE -> no restart.
